// File: rtl/seq_mult_4x4.sv
// Sequential 4x4 unsigned shift-and-add multiplier with a start/busy/done handshake.
// Each RUN cycle adds the gated multiplicand into the high accumulator, then shifts {carry,S,Q} right by one.
module seq_mult_4x4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned RES_W = 2 * OP_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [OP_W-1:0]  m, m_next;
  logic [OP_W-1:0]  acc, acc_next;
  logic [OP_W-1:0]  q, q_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [RES_W-1:0] prod, prod_next;
  logic             busy_next, done_next;

  // Four-bit adder stage: A = ACC, B = multiplicand gated by the multiplier LSB.
  logic [OP_W-1:0] add_b;
  logic [OP_W-1:0] add_s;
  logic            add_carry;

  always_comb begin
    add_b              = q[0] ? m : '0;
    {add_carry, add_s} = (OP_W + 1)'(acc) + (OP_W + 1)'(add_b);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      cnt   <= '0;
      prod  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      m     <= m_next;
      acc   <= acc_next;
      q     <= q_next;
      cnt   <= cnt_next;
      prod  <= prod_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_next = state;
    m_next     = m;
    acc_next   = acc;
    q_next     = q;
    cnt_next   = cnt;
    prod_next  = prod;
    unique case (state)
      IDLE: begin
        if (start) begin
          m_next     = a;
          q_next     = b;
          acc_next   = '0;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        // The adder carry becomes the new ACC MSB; it is never dropped.
        acc_next = {add_carry, add_s[OP_W-1:1]};
        q_next   = {add_s[0], q[OP_W-1:1]};
        cnt_next = cnt + CNT_W'(1);
        if (cnt == CNT_W'(OP_W - 1)) begin
          prod_next  = {acc_next, q_next};
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Handshake flags are registered from the next state so they track the state register.
    busy_next = (state_next == RUN);
    done_next = (state_next == DONE);
  end

  assign product = prod;

endmodule
